// File: rtl/panda_pkg.sv
// Shared types and access-size helpers for the Panda load-store unit.
// Byte enables and store lanes are derived here so the top stays focused on sequencing.
package panda_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'b00,
        LSU_MISALIGN    = 2'b01,
        LSU_REQ         = 2'b10,
        LSU_WAIT_RVALID = 2'b11
    } lsu_state_e;

    function automatic logic lsu_misaligned(input lsu_type_e size, input logic [1:0] off);
        logic bad;
        case (size)
            LSU_HALF: bad = off[0];
            LSU_WORD: bad = (off != 2'b00);
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lsu_be(input lsu_type_e size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LSU_BYTE: be = 4'b0001 << off;
            LSU_HALF: be = 4'b0011 << off;
            LSU_WORD: be = 4'b1111;
            default:  be = 4'b0001 << off;
        endcase
        return be;
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] lsu_lanes(input lsu_type_e size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            LSU_BYTE: lanes = {4{wdata[7:0]}};
            LSU_HALF: lanes = {2{wdata[15:0]}};
            LSU_WORD: lanes = wdata;
            default:  lanes = {4{wdata[7:0]}};
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/panda_lsu_checker.sv
// Protocol properties for the load-store unit: no request while an access is in flight,
// and a pending bus request keeps its address, lanes and direction steady.
module panda_lsu_checker (
    input logic        clk_i,
    input logic        rst_i,
    input logic        lsu_req_i,
    input logic        lsu_idle,
    input logic        data_req_o,
    input logic        data_gnt_i,
    input logic [31:0] data_addr_o,
    input logic [3:0]  data_be_o,
    input logic [31:0] data_wdata_o,
    input logic        data_we_o
);

    a_req_only_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        lsu_req_i |-> lsu_idle);

    a_bus_stable_until_gnt: assert property (@(posedge clk_i) disable iff (rst_i)
        (data_req_o && !data_gnt_i) |=> ($stable(data_addr_o) && $stable(data_be_o)
                                         && $stable(data_wdata_o) && $stable(data_we_o)));

endmodule

// File: rtl/panda_lsu_extend.sv
// Aligns the addressed byte/half of a bus word to bit 0 and zero- or sign-extends it.
module panda_lsu_extend
    import panda_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  lsu_type_e   lsu_type,
    input  logic        sign,
    output logic [31:0] ext
);

    logic [31:0] shifted_s;

    // Lane shift followed by size-dependent extension.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        case (lsu_type)
            LSU_BYTE: ext = {{24{sign & shifted_s[7]}}, shifted_s[7:0]};
            LSU_HALF: ext = {{16{sign & shifted_s[15]}}, shifted_s[15:0]};
            LSU_WORD: ext = rdata;
            default:  ext = shifted_s;
        endcase
    end

endmodule

// File: rtl/panda_lsu.sv
// Load-store unit of the Panda RV32I core: one byte/half/word access per request on a
// req/gnt/rvalid bus, with misalignment trap and a bus watchdog.
module panda_lsu
    import panda_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  lsu_type_e   lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_valid_o,
    output logic        lsu_err_o,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TimeoutCycles);
    localparam bit         WDOG_EN       = (TimeoutCycles != 32'd0);

    lsu_state_e  state_r, state_nxt_s;
    logic [7:0]  cnt_r;
    logic [29:0] addr_r;
    logic        we_r;
    lsu_type_e   type_r;
    logic        sign_r;
    logic [1:0]  off_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        req_r;
    logic [31:0] rdata_r;
    logic        valid_r;
    logic        err_r;

    logic        accept_s;
    logic        timeout_s;
    logic        done_s;
    logic        done_err_s;
    logic [31:0] done_data_s;
    logic [31:0] ext_s;

    panda_lsu_extend u_extend (
        .rdata    (data_rdata_i),
        .offset   (off_r),
        .lsu_type (type_r),
        .sign     (sign_r),
        .ext      (ext_s)
    );

    // Next-state and completion decode; the watchdog wins over grant/response in its cycle.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        done_err_s  = 1'b0;
        done_data_s = 32'h0000_0000;
        timeout_s   = WDOG_EN && (cnt_r == TIMEOUT_LIMIT);
        case (state_r)
            LSU_IDLE: begin
                if (lsu_req_i) begin
                    if (lsu_misaligned(lsu_type_i, lsu_addr_i[1:0])) begin
                        state_nxt_s = LSU_MISALIGN;
                    end else begin
                        accept_s    = 1'b1;
                        state_nxt_s = LSU_REQ;
                    end
                end else begin
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_MISALIGN: begin
                state_nxt_s = LSU_IDLE;
                done_s      = 1'b1;
                done_err_s  = 1'b1;
            end
            LSU_REQ: begin
                if (timeout_s) begin
                    state_nxt_s = LSU_IDLE;
                    done_s      = 1'b1;
                    done_err_s  = 1'b1;
                end else if (data_gnt_i) begin
                    state_nxt_s = LSU_WAIT_RVALID;
                end else begin
                    state_nxt_s = LSU_REQ;
                end
            end
            LSU_WAIT_RVALID: begin
                if (timeout_s) begin
                    state_nxt_s = LSU_IDLE;
                    done_s      = 1'b1;
                    done_err_s  = 1'b1;
                end else if (data_rvalid_i) begin
                    state_nxt_s = LSU_IDLE;
                    done_s      = 1'b1;
                    done_err_s  = data_err_i;
                    done_data_s = (we_r || data_err_i) ? 32'h0000_0000 : ext_s;
                end else begin
                    state_nxt_s = LSU_WAIT_RVALID;
                end
            end
            default: begin
                state_nxt_s = LSU_IDLE;
            end
        endcase
    end

    // State register and watchdog counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= LSU_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cnt_r <= 8'd0;
            end else if (state_r == LSU_REQ || state_r == LSU_WAIT_RVALID) begin
                cnt_r <= cnt_r + 8'd1;
            end
        end
    end

    // Access attributes captured at acceptance and presented on the bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_r  <= 30'd0;
            we_r    <= 1'b0;
            type_r  <= LSU_BYTE;
            sign_r  <= 1'b0;
            off_r   <= 2'b00;
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            req_r   <= 1'b0;
        end else begin
            req_r <= (state_nxt_s == LSU_REQ);
            if (accept_s) begin
                addr_r  <= lsu_addr_i[31:2];
                we_r    <= lsu_we_i;
                type_r  <= lsu_type_i;
                sign_r  <= lsu_sign_ext_i;
                off_r   <= lsu_addr_i[1:0];
                be_r    <= lsu_be(lsu_type_i, lsu_addr_i[1:0]);
                wdata_r <= lsu_lanes(lsu_type_i, lsu_wdata_i);
            end
        end
    end

    // Completion outputs: valid pulses, data and error hold until the next completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            valid_r <= done_s;
            if (done_s) begin
                err_r   <= done_err_s;
                rdata_r <= done_data_s;
            end
        end
    end

    assign lsu_rdata_o  = rdata_r;
    assign lsu_valid_o  = valid_r;
    assign lsu_err_o    = err_r;
    assign lsu_busy_o   = (state_r != LSU_IDLE) | lsu_req_i;
    assign data_req_o   = req_r;
    assign data_addr_o  = {addr_r, 2'b00};
    assign data_we_o    = we_r;
    assign data_be_o    = be_r;
    assign data_wdata_o = wdata_r;

    panda_lsu_checker u_checker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lsu_req_i    (lsu_req_i),
        .lsu_idle     (state_r == LSU_IDLE),
        .data_req_o   (req_r),
        .data_gnt_i   (data_gnt_i),
        .data_addr_o  (data_addr_o),
        .data_be_o    (be_r),
        .data_wdata_o (wdata_r),
        .data_we_o    (we_r)
    );

endmodule

// File: tb/tb_panda_lsu.sv
// Scoreboard bench for panda_lsu: stimulus queues expected completions, monitors pop and compare.
// A second instance with a short watchdog exercises the bus timeout path.
module tb_panda_lsu;
    import panda_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_sign = 1'b0;
    lsu_type_e   lsu_type = LSU_WORD;
    logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
    logic        gnt = 1'b0, rvalid = 1'b0, derr = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic [31:0] lsu_rdata_o, data_addr_o, data_wdata_o;
    logic        lsu_valid_o, lsu_err_o, lsu_busy_o, data_req_o, data_we_o;
    logic [3:0]  data_be_o;

    logic        wd_req = 1'b0, wd_gnt = 1'b0, wd_rvalid = 1'b0;
    logic [31:0] wd_rdata_o, wd_addr_o, wd_wdata_o;
    logic        wd_valid_o, wd_err_o, wd_busy_o, wd_data_req_o, wd_we_o;
    logic [3:0]  wd_be_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t wq[$];
    exp_t mon_e, wmon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    panda_lsu dut (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
        .lsu_sign_ext_i(lsu_sign), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_rdata_o(lsu_rdata_o), .lsu_valid_o(lsu_valid_o), .lsu_err_o(lsu_err_o),
        .lsu_busy_o(lsu_busy_o),
        .data_req_o(data_req_o), .data_gnt_i(gnt), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(rvalid), .data_rdata_i(bus_rdata), .data_err_i(derr)
    );

    panda_lsu #(.TimeoutCycles(4)) dut_wd (
        .clk_i(clk), .rst_i(rst),
        .lsu_req_i(wd_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
        .lsu_sign_ext_i(lsu_sign), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_rdata_o(wd_rdata_o), .lsu_valid_o(wd_valid_o), .lsu_err_o(wd_err_o),
        .lsu_busy_o(wd_busy_o),
        .data_req_o(wd_data_req_o), .data_gnt_i(wd_gnt), .data_addr_o(wd_addr_o),
        .data_we_o(wd_we_o), .data_be_o(wd_be_o), .data_wdata_o(wd_wdata_o),
        .data_rvalid_i(wd_rvalid), .data_rdata_i(bus_rdata), .data_err_i(derr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main-instance monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (lsu_valid_o) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid with rdata %h expected no completion (cycle %0d)",
                         lsu_rdata_o, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rdata", lsu_rdata_o, mon_e.rdata);
                chk("err", {31'b0, lsu_err_o}, {31'b0, mon_e.err});
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    // Watchdog-instance monitor.
    always @(negedge clk) begin
        if (wd_valid_o) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wd_unexpected_valid: got valid expected no completion (cycle %0d)", cyc);
            end else begin
                wmon_e = wq.pop_front();
                chk("wd_rdata", wd_rdata_o, wmon_e.rdata);
                chk("wd_err", {31'b0, wd_err_o}, {31'b0, wmon_e.err});
                chk("wd_latency", cyc, wmon_e.cyc);
            end
        end
    end

    // One aligned access; rvalid is also waved while still in REQ to show it is ignored there.
    task automatic access(input logic we, input lsu_type_e t, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wdata, input int gdelay,
                          input logic [31:0] brdata, input logic berr,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input logic e_err);
        chk("busy_idle", {31'b0, lsu_busy_o}, 32'd0);
        lsu_req = 1'b1; lsu_we = we; lsu_type = t; lsu_sign = sg;
        lsu_addr = addr; lsu_wdata = wdata;
        q.push_back('{e_rdata, e_err, cyc + 3 + gdelay});
        tick();
        lsu_req = 1'b0;
        for (int i = 0; i <= gdelay; i++) begin
            gnt       = (i == gdelay);
            rvalid    = (i != gdelay);
            bus_rdata = 32'h5A5A_5A5A;
            chk("bus_req", {31'b0, data_req_o}, 32'd1);
            chk("bus_addr", data_addr_o, {addr[31:2], 2'b00});
            chk("bus_be", {28'b0, data_be_o}, {28'b0, e_be});
            chk("bus_wdata", data_wdata_o, e_wdata);
            chk("bus_we", {31'b0, data_we_o}, {31'b0, we});
            tick();
        end
        gnt = 1'b0;
        chk("req_drop", {31'b0, data_req_o}, 32'd0);
        rvalid = 1'b1; bus_rdata = brdata; derr = berr;
        tick();
        rvalid = 1'b0; derr = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic misaligned(input lsu_type_e t, input logic [31:0] addr);
        chk("busy_idle", {31'b0, lsu_busy_o}, 32'd0);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = t; lsu_sign = 1'b0; lsu_addr = addr;
        q.push_back('{32'h0, 1'b1, cyc + 2});
        tick();
        lsu_req = 1'b0;
        chk("misalign_noreq", {31'b0, data_req_o}, 32'd0);
        tick();
        chk("misalign_noreq", {31'b0, data_req_o}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, lsu_valid_o}, 32'd0);
        chk("rst_err", {31'b0, lsu_err_o}, 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        chk("rst_req", {31'b0, data_req_o}, 32'd0);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_be", {28'b0, data_be_o}, 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_we", {31'b0, data_we_o}, 32'd0);
        rst = 1'b0;
        tick();

        access(1'b0, LSU_WORD, 1'b0, 32'h100, 32'h1122_3344, 0, 32'hDEAD_BEEF, 1'b0,
               4'b1111, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, LSU_BYTE, 1'b1, 32'h103, 32'h0, 0, 32'h80FF_1234, 1'b0,
               4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
        access(1'b0, LSU_HALF, 1'b0, 32'h102, 32'h0, 0, 32'h80FF_1234, 1'b0,
               4'b1100, 32'h0, 32'h0000_80FF, 1'b0);
        access(1'b0, LSU_BYTE, 1'b0, 32'h101, 32'h0, 0, 32'h80FF_1234, 1'b0,
               4'b0010, 32'h0, 32'h0000_0012, 1'b0);
        access(1'b0, LSU_HALF, 1'b1, 32'h100, 32'h0, 0, 32'h80FF_1234, 1'b0,
               4'b0011, 32'h0, 32'h0000_1234, 1'b0);
        access(1'b0, LSU_HALF, 1'b1, 32'h102, 32'h0, 1, 32'h80FF_1234, 1'b0,
               4'b1100, 32'h0, 32'hFFFF_80FF, 1'b0);
        access(1'b1, LSU_BYTE, 1'b0, 32'h201, 32'h0000_00A5, 3, 32'h1234_5678, 1'b0,
               4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0);
        access(1'b1, LSU_HALF, 1'b0, 32'h202, 32'h1234_BEEF, 1, 32'h1234_5678, 1'b0,
               4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0);
        access(1'b1, LSU_WORD, 1'b0, 32'h300, 32'hCAFE_F00D, 0, 32'h1234_5678, 1'b0,
               4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0);
        access(1'b0, LSU_WORD, 1'b0, 32'h108, 32'h0, 0, 32'h5555_5555, 1'b1,
               4'b1111, 32'h0, 32'h0, 1'b1);
        misaligned(LSU_WORD, 32'h102);
        misaligned(LSU_HALF, 32'h101);
        misaligned(LSU_WORD, 32'h103);
        access(1'b0, LSU_WORD, 1'b1, 32'h104, 32'h0, 0, 32'h8000_0000, 1'b0,
               4'b1111, 32'h0, 32'h8000_0000, 1'b0);

        // Response while idle must not produce a completion.
        tick();
        rvalid = 1'b1; bus_rdata = 32'h1357_9BDF;
        tick();
        rvalid = 1'b0;
        tick();
        chk("idle_rvalid_ignored", {31'b0, lsu_valid_o}, 32'd0);

        // Reset while waiting for the response.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = LSU_WORD; lsu_addr = 32'h10C;
        lsu_wdata = 32'h7777_7777;
        tick();
        lsu_req = 1'b0; gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, lsu_valid_o}, 32'd0);
        chk("arst_rdata", lsu_rdata_o, 32'd0);
        chk("arst_err", {31'b0, lsu_err_o}, 32'd0);
        chk("arst_req", {31'b0, data_req_o}, 32'd0);
        chk("arst_addr", data_addr_o, 32'd0);
        chk("arst_be", {28'b0, data_be_o}, 32'd0);
        chk("arst_wdata", data_wdata_o, 32'd0);
        tick();
        rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        tick();
        rvalid = 1'b0;
        rst = 1'b0;
        tick();
        access(1'b0, LSU_WORD, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
               4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Watchdog of 4 cycles with the grant never arriving.
        wd_req = 1'b1; lsu_we = 1'b0; lsu_type = LSU_WORD; lsu_addr = 32'h400;
        wq.push_back('{32'h0, 1'b1, cyc + 6});
        tick();
        wd_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("wd_req_held", {31'b0, wd_data_req_o}, 32'd1);
            tick();
        end
        chk("wd_req_dropped", {31'b0, wd_data_req_o}, 32'd0);
        tick();
        wd_rvalid = 1'b1;
        tick();
        wd_rvalid = 1'b0;
        tick();
        chk("wd_late_rvalid_ignored", {31'b0, wd_valid_o}, 32'd0);

        for (int i = 0; i < 10 && (q.size() + wq.size()) != 0; i++) tick();
        chk("queues_drained", q.size() + wq.size(), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/panda_lsu.md
Name: panda_lsu

Overview:
Load-store unit of the Panda RV32I core. It sits directly downstream of the ALU and consumes the adder result as the effective address. It performs one byte, half or word access on a req/gnt/rvalid data-memory bus, and returns the aligned, extended load data to writeback. The pipeline controller stalls on lsu_busy_o.

Parameters:
TimeoutCycles, 255, bus watchdog limit in cycles spent in REQ plus WAIT_RVALID; 0 disables the watchdog; counter is 8 bits wide.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
lsu_req_i  in  1  single-cycle access request from EX; only legal while lsu_busy_o was low in the prior cycle
lsu_we_i  in  1  1 = store, 0 = load
lsu_type_i  in  lsu_type_e (2)  access size
lsu_sign_ext_i  in  1  sign-extend load data (LB/LH)
lsu_addr_i  in  32  effective address (ALU adder result)
lsu_wdata_i  in  32  store data (rs2)
lsu_rdata_o  out  32  extended load data, registered
lsu_valid_o  out  1  one-cycle completion pulse, registered
lsu_err_o  out  1  error flag, valid only with lsu_valid_o
lsu_busy_o  out  1  combinational: (state != IDLE) | lsu_req_i
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-replicated store data
data_rvalid_i  in  1  response valid
data_rdata_i  in  32  response data
data_err_i  in  1  response error, sampled with rvalid

Behaviour:
- Reset values: lsu_rdata_o=0, lsu_valid_o=0, lsu_err_o=0, all data_* outputs 0, state IDLE, counter 0. An asserted reset mid-access aborts immediately and drops data_req_o; no completion is reported.
- States: IDLE, MISALIGN, REQ, WAIT_RVALID.
- IDLE + lsu_req_i, address misaligned (HALF with addr[0]=1, or WORD with addr[1:0]!=0):
  - go to MISALIGN; no bus request is issued.
  - MISALIGN lasts one cycle, then IDLE with lsu_valid_o=1, lsu_err_o=1, lsu_rdata_o=0.
- IDLE + lsu_req_i, aligned:
  - register address, we, type, sign, offset=addr[1:0], byte enables and store data.
  - go to REQ.
- Byte enables: BYTE 4'b0001<<off; HALF 4'b0011<<off; WORD 4'b1111.
- Store data: BYTE {4{wdata[7:0]}}; HALF {2{wdata[15:0]}}; WORD wdata.
- REQ:
  - data_req_o=1; all data_* outputs driven from registers and held stable until data_gnt_i.
  - on grant go to WAIT_RVALID; data_req_o deasserts in that cycle.
- WAIT_RVALID:
  - on data_rvalid_i: next cycle lsu_valid_o=1, lsu_err_o=data_err_i, state IDLE.
  - loads: lsu_rdata_o = extend(data_rdata_i >> 8*off); stores and errors: lsu_rdata_o=0.
- rvalid is sampled only in WAIT_RVALID; rvalid in IDLE or REQ is ignored.
- Minimum latency: lsu_req_i at cycle 0 → data_req_o at 1 → gnt at 1 → rvalid at 2 → lsu_valid_o at 3.
- lsu_busy_o is low in the lsu_valid_o cycle, so a back-to-back lsu_req_i is accepted then.
- Watchdog:
  - counter clears on leaving IDLE and increments each cycle in REQ/WAIT_RVALID.
  - when the counter equals TimeoutCycles (≠0), abort: data_req_o drops, next cycle lsu_valid_o=1 with lsu_err_o=1, state IDLE.
  - a late rvalid after abort is ignored.
- Extension: BYTE uses bits [7:0], HALF uses [15:0]; the upper bits are the sign bit if lsu_sign_ext_i, else 0. WORD passes through and ignores lsu_sign_ext_i.
- lsu_rdata_o and lsu_err_o hold their values between completions; lsu_valid_o is a pulse.
- lsu_req_i while busy is a protocol violation: ignored, and flagged by an assertion.

Decomposition:
- panda_pkg gets:
  - lsu_type_e {LSU_BYTE=2'b00, LSU_HALF=2'b01, LSU_WORD=2'b10}
  - lsu_state_e {LSU_IDLE, LSU_MISALIGN, LSU_REQ, LSU_WAIT_RVALID}
- One combinational sub-module, panda_lsu_extend: inputs rdata, offset, type and sign; output the 32-bit extended load value.

Test Plan:
- LW at addr 0x100, gnt same cycle, rdata 0xDEADBEEF at cycle 2 → data_addr_o=0x100, be=1111, lsu_valid_o at cycle 3 with lsu_rdata_o=0xDEADBEEF, err=0.
- LB signed at 0x103, rdata 0x80FF_1234 → be=1000, rdata_o=0xFFFFFF80. LHU at 0x102, same rdata → 0x000080FF.
- SB at 0x201, wdata 0x000000A5, gnt held low 3 cycles → req/addr/be=0010/wdata=0xA5A5A5A5 stable until gnt; valid after rvalid, rdata_o=0.
- LW at 0x102 → no data_req_o; valid=1, err=1 exactly two cycles after lsu_req_i.
- TimeoutCycles=4 and gnt never asserted → req dropped; valid=1, err=1. Separately, data_err_i=1 with rvalid → err=1.
- Reset asserted while in WAIT_RVALID → all outputs 0 immediately. After release, a new LW completes normally and no stale valid appears.
